// File: rtl/axi_mst_pkg.sv
// axi_mst_pkg: AXI constants, FSM state type and size helper shared by the AXI masters.
package axi_mst_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        INIT_ST,
        READ_REGS_ST,
        INIT_ADDR_ST,
        INCR_ADDR_ST,
        ADDR_ST,
        DATA_ST,
        NBURST_ST,
        END_ST
    } rd_state_t;

    function automatic logic [2:0] axsize_from_bytes(input int bytes);
        return 3'($clog2(bytes));
    endfunction
endpackage

// File: rtl/axi_mst_read_if.sv
// axi_mst_read_if: AXI read address/data channels plus the AXI-Stream output of the read master.
interface axi_mst_read_if #(
    parameter int ID_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int B_BURST_LENGTH = 4
);
    logic [ID_WIDTH-1:0]       m_axi_arid;
    logic [31:0]               m_axi_araddr;
    logic [B_BURST_LENGTH-1:0] m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic [1:0]                m_axi_arburst;
    logic [1:0]                m_axi_arlock;
    logic [3:0]                m_axi_arcache;
    logic [2:0]                m_axi_arprot;
    logic [3:0]                m_axi_arqos;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [ID_WIDTH-1:0]       m_axi_rid;
    logic [DATA_WIDTH-1:0]     m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rlast;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;
    logic                      m_axis_tready;
    logic [DATA_WIDTH-1:0]     m_axis_tdata;
    logic [DATA_WIDTH/8-1:0]   m_axis_tstrb;
    logic                      m_axis_tlast;
    logic                      m_axis_tvalid;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
               m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
               m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tvalid,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
               m_axis_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
               m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
               m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tvalid,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
               m_axis_tready
    );
endinterface

// File: rtl/fifo_axi.sv
// fifo_axi: first-word-fall-through FIFO; push while full is accepted when a pop frees a slot.
module fifo_axi #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             push, pop;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign pop   = rd_en && !empty;
    assign push  = wr_en && (!full || pop);
    assign dout  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push ? wr_q + 1'b1 : wr_q;
            rd_q  <= pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/axi_mst_read.sv
// axi_mst_read: issues NBURST fixed-length INCR read bursts, one at a time, and streams the beats out over AXIS.
module axi_mst_read
    import axi_mst_pkg::*;
#(
    parameter int ID_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LENGTH = 7,
    parameter int B_BURST_LENGTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    axi_mst_read_if.master      m,
    input  logic                START_REG,
    input  logic [31:0]         ADDR_REG,
    input  logic [31:0]         NBURST_REG,
    output logic                IDLE_REG,
    output logic                ERR_REG
);
    localparam logic [31:0] BURST_BYTES = 32'((BURST_LENGTH + 1) * DATA_WIDTH / 8);
    localparam logic [B_BURST_LENGTH-1:0] LAST_BEAT = B_BURST_LENGTH'(BURST_LENGTH);

    rd_state_t                 state_q;
    logic [31:0]               base_q, nburst_q, burst_q, araddr_q;
    logic [B_BURST_LENGTH-1:0] beat_q;
    logic                      arvalid_q, err_q;
    logic                      fifo_full, fifo_empty;
    logic [DATA_WIDTH:0]       fifo_dout;
    logic                      beat_ok, last_beat, final_beat;
    logic                      unused_rid;

    assign unused_rid = ^m.m_axi_rid;
    assign beat_ok    = m.m_axi_rvalid && m.m_axi_rready;
    assign last_beat  = beat_q == LAST_BEAT;
    assign final_beat = last_beat && (burst_q + 32'd1 == nburst_q);

    assign m.m_axi_arid    = '0;
    assign m.m_axi_araddr  = araddr_q;
    assign m.m_axi_arlen   = LAST_BEAT;
    assign m.m_axi_arsize  = axsize_from_bytes(DATA_WIDTH / 8);
    assign m.m_axi_arburst = AXI_BURST_INCR;
    assign m.m_axi_arlock  = '0;
    assign m.m_axi_arcache = '0;
    assign m.m_axi_arprot  = '0;
    assign m.m_axi_arqos   = '0;
    assign m.m_axi_arvalid = arvalid_q;
    assign m.m_axi_rready  = (state_q == DATA_ST) && !fifo_full;
    assign m.m_axis_tvalid = !fifo_empty;
    assign m.m_axis_tdata  = fifo_dout[DATA_WIDTH-1:0];
    assign m.m_axis_tlast  = fifo_dout[DATA_WIDTH] && !fifo_empty;
    assign m.m_axis_tstrb  = '1;
    assign IDLE_REG        = state_q == INIT_ST;
    assign ERR_REG         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_ST;
            base_q    <= '0;
            nburst_q  <= '0;
            burst_q   <= '0;
            araddr_q  <= '0;
            beat_q    <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT_ST: if (START_REG) state_q <= READ_REGS_ST;
                READ_REGS_ST: begin
                    base_q   <= ADDR_REG;
                    nburst_q <= NBURST_REG;
                    burst_q  <= '0;
                    err_q    <= 1'b0;
                    state_q  <= NBURST_REG == '0 ? END_ST : INIT_ADDR_ST;
                end
                INIT_ADDR_ST: begin
                    araddr_q  <= base_q;
                    arvalid_q <= 1'b1;
                    state_q   <= ADDR_ST;
                end
                INCR_ADDR_ST: begin
                    araddr_q  <= araddr_q + BURST_BYTES;
                    arvalid_q <= 1'b1;
                    state_q   <= ADDR_ST;
                end
                ADDR_ST: begin
                    beat_q <= '0;
                    if (m.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= DATA_ST;
                    end
                end
                // Beat counting follows our own counter; a misplaced rlast only flags an error.
                DATA_ST: if (beat_ok) begin
                    if (m.m_axi_rresp != AXI_RESP_OKAY || m.m_axi_rlast != last_beat) err_q <= 1'b1;
                    if (last_beat) begin
                        burst_q <= burst_q + 32'd1;
                        state_q <= NBURST_ST;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                NBURST_ST: state_q <= burst_q == nburst_q ? END_ST : INCR_ADDR_ST;
                END_ST: if (!START_REG && fifo_empty) state_q <= INIT_ST;
                default: state_q <= INIT_ST;
            endcase
        end
    end

    fifo_axi #(.WIDTH(DATA_WIDTH + 1), .DEPTH(16)) u_fifo (
        .clk  (clk),
        .rstn (~rst),
        .wr_en(beat_ok),
        .din  ({final_beat, m.m_axi_rdata}),
        .rd_en(m.m_axis_tvalid && m.m_axis_tready),
        .full (fifo_full),
        .empty(fifo_empty),
        .dout (fifo_dout)
    );
endmodule

// File: tb/tb_axi_mst_read.sv
// tb_axi_mst_read: directed bench with a one-burst-at-a-time AXI read slave and an AXIS sink.
module tb_axi_mst_read;
    localparam logic [63:0] BASE = 64'hA5A5_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr_reg = '0;
    logic [31:0] nburst_reg = '0;
    logic        idle, err;
    int          checks = 0, errors = 0;
    int          n_ar = 0, n_out = 0, seq = 0, burst_no = 0, pend = 0, beat = 0;
    int          err_burst = -1, err_beat = -1;
    logic [31:0] ar_log [32];
    logic [63:0] out_data [64];
    logic        out_last [64];

    axi_mst_read_if #(.ID_WIDTH(6), .DATA_WIDTH(64), .B_BURST_LENGTH(4)) bus ();

    axi_mst_read #(.ID_WIDTH(6), .DATA_WIDTH(64), .BURST_LENGTH(7), .B_BURST_LENGTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .m         (bus),
        .START_REG (start),
        .ADDR_REG  (addr_reg),
        .NBURST_REG(nburst_reg),
        .IDLE_REG  (idle),
        .ERR_REG   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave: handshakes observed at negedge, responses updated 1 unit after the edge.
    initial begin
        logic hs_ar, hs_r, in_rst;
        logic [31:0] a;
        bus.m_axi_arready = 1'b1;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0;
        bus.m_axi_rresp = 2'b00;
        bus.m_axi_rlast = 1'b0;
        bus.m_axi_rid = '0;
        forever begin
            @(negedge clk);
            hs_ar = bus.m_axi_arvalid && bus.m_axi_arready;
            hs_r = bus.m_axi_rvalid && bus.m_axi_rready;
            in_rst = rst;
            a = bus.m_axi_araddr;
            @(posedge clk);
            #1;
            if (in_rst) begin
                pend = 0;
                beat = 0;
                bus.m_axi_rvalid = 1'b0;
            end else begin
                if (hs_ar) begin
                    if (n_ar < 32) ar_log[n_ar] = a;
                    n_ar++;
                    pend++;
                end
                if (hs_r) begin
                    seq++;
                    beat++;
                    if (beat == 8) begin
                        beat = 0;
                        pend--;
                        burst_no++;
                    end
                end
                bus.m_axi_rvalid = pend > 0;
                bus.m_axi_rdata = BASE + 64'(seq);
                bus.m_axi_rlast = beat == 7;
                bus.m_axi_rresp = (burst_no == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.m_axis_tvalid && bus.m_axis_tready && n_out < 64) begin
                out_data[n_out] = bus.m_axis_tdata;
                out_last[n_out] = bus.m_axis_tlast;
                n_out++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        n_ar = 0;
        n_out = 0;
        seq = 0;
        burst_no = 0;
    endtask

    task automatic wait_out(input string tag, input int n);
        for (int i = 0; i < 2000 && n_out < n; i++) tick();
        check({tag, "_beats"}, 64'(n_out), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && !idle; i++) tick();
        check({tag, "_idle"}, 64'(idle), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_data%0d", tag, k), out_data[k], BASE + 64'(k));
            check($sformatf("%s_last%0d", tag, k), 64'(out_last[k]), 64'(k == n - 1));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, 64'(bus.m_axi_arvalid), 64'd0);
        check({tag, "_rready"}, 64'(bus.m_axi_rready), 64'd0);
        check({tag, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
        check({tag, "_tlast"}, 64'(bus.m_axis_tlast), 64'd0);
        check({tag, "_idle"}, 64'(idle), 64'd1);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        bus.m_axis_tready = 1'b1;
        tick(3);
        check_quiet("reset");
        rst = 1'b0;
        tick();
        check("arid", 64'(bus.m_axi_arid), 64'd0);
        check("arlen", 64'(bus.m_axi_arlen), 64'd7);
        check("arsize", 64'(bus.m_axi_arsize), 64'd3);
        check("arburst", 64'(bus.m_axi_arburst), 64'd1);
        check("arlock", 64'(bus.m_axi_arlock), 64'd0);
        check("arcache", 64'(bus.m_axi_arcache), 64'd0);
        check("arprot", 64'(bus.m_axi_arprot), 64'd0);
        check("arqos", 64'(bus.m_axi_arqos), 64'd0);
        check("tstrb", 64'(bus.m_axis_tstrb), 64'hff);

        // Three bursts from 0x1000, free-flowing sink.
        clear_log();
        addr_reg = 32'h1000;
        nburst_reg = 32'd3;
        start = 1'b1;
        tick();
        check("r1_busy", 64'(idle), 64'd0);
        wait_out("r1", 24);
        start = 1'b0;
        wait_idle("r1");
        check("r1_count", 64'(n_out), 64'd24);
        check("r1_nar", 64'(n_ar), 64'd3);
        check("r1_ar0", 64'(ar_log[0]), 64'h1000);
        check("r1_ar1", 64'(ar_log[1]), 64'h1040);
        check("r1_ar2", 64'(ar_log[2]), 64'h1080);
        check_stream("r1", 24);
        check("r1_err", 64'(err), 64'd0);

        // Zero bursts: parks in END_ST until START drops.
        clear_log();
        nburst_reg = 32'd0;
        start = 1'b1;
        tick(3);
        check("r2_busy", 64'(idle), 64'd0);
        check("r2_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        start = 1'b0;
        tick(2);
        check("r2_idle", 64'(idle), 64'd1);
        check("r2_nar", 64'(n_ar), 64'd0);
        check("r2_nout", 64'(n_out), 64'd0);

        // Sink stalled: FIFO fills at 16 beats, START dropped mid-transfer.
        clear_log();
        addr_reg = 32'h4000;
        nburst_reg = 32'd4;
        bus.m_axis_tready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(40);
        check("r3_accepted", 64'(seq), 64'd16);
        check("r3_rready", 64'(bus.m_axi_rready), 64'd0);
        check("r3_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        check("r3_busy", 64'(idle), 64'd0);
        bus.m_axis_tready = 1'b1;
        wait_out("r3", 32);
        wait_idle("r3");
        check("r3_count", 64'(n_out), 64'd32);
        check("r3_nar", 64'(n_ar), 64'd4);
        check("r3_ar3", 64'(ar_log[3]), 64'h40C0);
        check_stream("r3", 32);

        // SLVERR on the third beat of the first burst.
        clear_log();
        err_burst = 0;
        err_beat = 2;
        addr_reg = 32'h8000;
        nburst_reg = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_out("r4", 16);
        wait_idle("r4");
        check("r4_err", 64'(err), 64'd1);
        check("r4_count", 64'(n_out), 64'd16);
        check_stream("r4", 16);

        // Address wrap past 2^32; error flag cleared by the new start.
        clear_log();
        err_burst = -1;
        err_beat = -1;
        addr_reg = 32'hFFFF_FFC0;
        nburst_reg = 32'd2;
        start = 1'b1;
        tick(2);
        check("r5_err_clr", 64'(err), 64'd0);
        start = 1'b0;
        wait_out("r5", 16);
        wait_idle("r5");
        check("r5_nar", 64'(n_ar), 64'd2);
        check("r5_ar0", 64'(ar_log[0]), 64'hFFFF_FFC0);
        check("r5_ar1", 64'(ar_log[1]), 64'h0);

        // Reset in the middle of a data phase, then a clean single burst.
        clear_log();
        addr_reg = 32'h2000;
        nburst_reg = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && !bus.m_axi_rready; i++) tick();
        check("r6_in_data", 64'(bus.m_axi_rready), 64'd1);
        tick(2);
        rst = 1'b1;
        tick();
        check_quiet("r6_rst");
        rst = 1'b0;
        tick();
        clear_log();
        addr_reg = 32'h3000;
        nburst_reg = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_out("r6", 8);
        wait_idle("r6");
        check("r6_nar", 64'(n_ar), 64'd1);
        check("r6_ar0", 64'(ar_log[0]), 64'h3000);
        check("r6_count", 64'(n_out), 64'd8);
        check_stream("r6", 8);
        check("r6_err", 64'(err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mst_read.md
AXI_MST_READ -- requirements
Module: axi_mst_read

Interface
REQ-001 SHALL have parameters: ID_WIDTH, default 6, AXI ID width; DATA_WIDTH, default 64, data bits per beat; BURST_LENGTH, default 7, ARLEN value (beats-1); B_BURST_LENGTH, default 4, ARLEN field width.
REQ-002 SHALL have ports: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have AR channel ports: m_axi_arid out ID_WIDTH; m_axi_araddr out 32; m_axi_arlen out B_BURST_LENGTH; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_arlock out 2; m_axi_arcache out 4; m_axi_arprot out 3; m_axi_arqos out 4; m_axi_arvalid out 1; m_axi_arready in 1.
REQ-004 SHALL have R channel ports: m_axi_rid in ID_WIDTH; m_axi_rdata in DATA_WIDTH; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1.
REQ-005 SHALL have AXIS master ports: m_axis_tready in 1; m_axis_tdata out DATA_WIDTH; m_axis_tstrb out DATA_WIDTH/8; m_axis_tlast out 1; m_axis_tvalid out 1.
REQ-006 SHALL have register ports: START_REG in 1; ADDR_REG in 32; NBURST_REG in 32; IDLE_REG out 1 (high in INIT_ST only); ERR_REG out 1 (sticky read error).

Function
REQ-007 Constants SHALL be fixed: arid=0, arlen=BURST_LENGTH, arsize=log2(DATA_WIDTH/8), arburst=INCR (01), arlock/arcache/arprot/arqos=0, tstrb all ones.
REQ-008 FSM states SHALL be INIT_ST, READ_REGS_ST, INIT_ADDR_ST, INCR_ADDR_ST, ADDR_ST, DATA_ST, NBURST_ST, END_ST.
REQ-009 INIT_ST -> READ_REGS_ST when START_REG=1; READ_REGS_ST latches ADDR_REG, NBURST_REG, clears burst count and ERR_REG.
REQ-010 READ_REGS_ST -> END_ST if latched NBURST=0 (no AXI traffic), else INIT_ADDR_ST; INIT_ADDR_ST loads araddr=latched ADDR -> ADDR_ST.
REQ-011 ADDR_ST drives arvalid=1; -> DATA_ST on arready=1; araddr stable while arvalid high.
REQ-012 DATA_ST drives rready = ~fifo_full; beat accepted on rvalid&rready; beat counter cleared in ADDR_ST; -> NBURST_ST on accepted beat with beat counter = BURST_LENGTH.
REQ-013 Burst counter SHALL increment on the final accepted beat of each burst; NBURST_ST -> END_ST when count = latched NBURST, else INCR_ADDR_ST.
REQ-014 INCR_ADDR_ST SHALL add (BURST_LENGTH+1)*DATA_WIDTH/8 to araddr, modulo 2^32 wrap, -> ADDR_ST; exactly NBURST bursts issued, one outstanding at a time.
REQ-015 END_ST -> INIT_ST only when START_REG=0 and FIFO empty.
REQ-016 Each accepted beat SHALL be written to FIFO as {tlast_flag, rdata}; tlast_flag=1 only on last beat of last burst.
REQ-017 AXIS side SHALL be FWFT: tvalid=~fifo_empty, tdata/tlast from FIFO head, pop on tvalid&tready; tdata/tlast held while tvalid&~tready.
REQ-018 ERR_REG SHALL set on accepted beat with rresp!=00, or rlast mismatching beat counter = BURST_LENGTH; beat counting ignores rlast; transfer still completes.
REQ-019 FIFO full SHALL stall R channel only (rready low); no data loss or duplication; simultaneous push and pop on full/empty SHALL be legal.
REQ-020 START_REG deassertion mid-transfer SHALL be ignored until END_ST.

Reset
REQ-021 rst=1 at any clock edge SHALL force INIT_ST, flush FIFO, clear counters, araddr, latched registers, ERR_REG.
REQ-022 During/after reset: arvalid=0, rready=0, tvalid=0, tlast=0, IDLE_REG=1 (from first cycle after reset); in-flight AXI transaction abandoned.

Structure
REQ-023 Shared package axi_mst_pkg SHALL hold AXI constants (INCR burst, OKAY resp) and the arsize-from-bytes function, reused by the write master.
REQ-024 Single sub-module fifo_axi, width DATA_WIDTH+1, depth 16, FWFT; its rstn driven by ~rst.

Verification
REQ-025 ADDR_REG=0x1000, NBURST=3, slave always ready, tready=1 -> ARADDR 0x1000,0x1040,0x1080; 24 beats out in order; tlast on beat 24 only.
REQ-026 NBURST=0, START pulse -> no arvalid, END_ST reached, IDLE_REG returns 1 after START=0.
REQ-027 NBURST=4, tready=0 for 40 cycles -> rready drops at 16 buffered beats, no loss; all 32 beats delivered once tready=1.
REQ-028 Slave returns rresp=10 on beat 3 of burst 1 -> ERR_REG=1, all beats still delivered; ERR_REG cleared on next START.
REQ-029 ADDR_REG=0xFFFFFFC0, NBURST=2 -> second ARADDR=0x00000000.
REQ-030 rst asserted mid-DATA_ST -> next cycle arvalid=0, rready=0, tvalid=0, IDLE_REG=1; following run with NBURST=1 completes cleanly.
